// File: rtl/wshb_if.sv
// Wishbone bundle shared by the display reader, the frame writer and the SDRAM port.
// master drives the request side; slave returns ack and read data.
interface wshb_if;
    logic [31:0] adr;
    logic [15:0] dat_ms;
    logic [15:0] dat_sm;
    logic [1:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (
        output adr, dat_ms, sel, we, stb, cyc, cti, bte,
        input  dat_sm, ack
    );

    modport slave (
        input  adr, dat_ms, sel, we, stb, cyc, cti, bte,
        output dat_sm, ack
    );
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller, with a beat-limited grant.
// Define ARB_PRIO_EN for fixed m0 priority (m0 never preempted); default is round-robin.
module wshb_arbiter #(
    parameter int MAX_GRANT = 64
) (
    input  logic   clk,
    input  logic   rst,
    wshb_if.slave  wshb_if_m0,
    wshb_if.slave  wshb_if_m1,
    wshb_if.master wshb_if_s
);
    localparam int BW = $clog2(MAX_GRANT + 1);

    if (MAX_GRANT < 1) begin : g_bad_max_grant
        $error("wshb_arbiter: MAX_GRANT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t        state_reg;
    logic [BW-1:0] beat_reg;
    logic [BW-1:0] beat_next;
    logic          cyc0;
    logic          cyc1;
    logic          beat_sat;
    logic          limit_hit;
    logic          pick0;
    logic          preempt0;
    logic          grant0;
    logic          grant1;

    assign cyc0      = wshb_if_m0.cyc;
    assign cyc1      = wshb_if_m1.cyc;
    assign beat_sat  = (beat_reg == BW'(MAX_GRANT));
    // An ack in this state completes beat MAX_GRANT (or later, once saturated).
    assign limit_hit = beat_sat || (beat_reg == BW'(MAX_GRANT - 1));
    assign beat_next = beat_sat ? beat_reg : beat_reg + 1'b1;

`ifdef ARB_PRIO_EN
    assign pick0    = 1'b1;
    assign preempt0 = 1'b0;
`else
    logic last_reg;

    // Most recently served master; only consulted in IDLE, so following the
    // grant state is the same as updating on each grant entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (state_reg == GRANT0) begin
            last_reg <= 1'b0;
        end else if (state_reg == GRANT1) begin
            last_reg <= 1'b1;
        end
    end

    assign pick0    = last_reg;
    assign preempt0 = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    beat_reg <= '0;
                    if (cyc0 && (!cyc1 || pick0)) begin
                        state_reg <= GRANT0;
                    end else if (cyc1) begin
                        state_reg <= GRANT1;
                    end
                end
                GRANT0: begin
                    if (!cyc0) begin
                        state_reg <= cyc1 ? GRANT1 : IDLE;
                        beat_reg  <= '0;
                    end else if (wshb_if_s.ack) begin
                        // Handover only on an ack edge, so a beat is never split.
                        if (preempt0 && limit_hit && cyc1) begin
                            state_reg <= GRANT1;
                            beat_reg  <= '0;
                        end else begin
                            beat_reg <= beat_next;
                        end
                    end
                end
                GRANT1: begin
                    if (!cyc1) begin
                        state_reg <= cyc0 ? GRANT0 : IDLE;
                        beat_reg  <= '0;
                    end else if (wshb_if_s.ack) begin
                        if (limit_hit && cyc0) begin
                            state_reg <= GRANT0;
                            beat_reg  <= '0;
                        end else begin
                            beat_reg <= beat_next;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    beat_reg  <= '0;
                end
            endcase
        end
    end

    // Reset gates the routing so nothing leaks through during the reset cycle.
    assign grant0 = (state_reg == GRANT0) && !rst;
    assign grant1 = (state_reg == GRANT1) && !rst;

    always_comb begin
        wshb_if_s.adr    = '0;
        wshb_if_s.dat_ms = '0;
        wshb_if_s.sel    = '0;
        wshb_if_s.we     = 1'b0;
        wshb_if_s.stb    = 1'b0;
        wshb_if_s.cyc    = 1'b0;
        wshb_if_s.cti    = '0;
        wshb_if_s.bte    = '0;
        if (grant0) begin
            wshb_if_s.adr    = wshb_if_m0.adr;
            wshb_if_s.dat_ms = wshb_if_m0.dat_ms;
            wshb_if_s.sel    = wshb_if_m0.sel;
            wshb_if_s.we     = wshb_if_m0.we;
            wshb_if_s.stb    = wshb_if_m0.stb;
            wshb_if_s.cyc    = wshb_if_m0.cyc;
            wshb_if_s.cti    = wshb_if_m0.cti;
            wshb_if_s.bte    = wshb_if_m0.bte;
        end else if (grant1) begin
            wshb_if_s.adr    = wshb_if_m1.adr;
            wshb_if_s.dat_ms = wshb_if_m1.dat_ms;
            wshb_if_s.sel    = wshb_if_m1.sel;
            wshb_if_s.we     = wshb_if_m1.we;
            wshb_if_s.stb    = wshb_if_m1.stb;
            wshb_if_s.cyc    = wshb_if_m1.cyc;
            wshb_if_s.cti    = wshb_if_m1.cti;
            wshb_if_s.bte    = wshb_if_m1.bte;
        end
    end

    assign wshb_if_m0.ack    = grant0 && wshb_if_s.ack;
    assign wshb_if_m1.ack    = grant1 && wshb_if_s.ack;
    assign wshb_if_m0.dat_sm = wshb_if_s.dat_sm;
    assign wshb_if_m1.dat_sm = wshb_if_s.dat_sm;
endmodule
